// File: rtl/micro_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// micro_sequencer_pkg
//   Shared defaults for the micro-sequencer and its return stack, plus the
//   encoding of the next-address source select used by the top-level mux.
//   DEF_* values are the default parameter values of micro_sequencer; a
//   parameter override on the top takes precedence over them.
// ---------------------------------------------------------------------------
package micro_sequencer_pkg;

   localparam int DEF_CAR_BITS     = 6;
   localparam int DEF_STACK_DEPTH  = 4;
   localparam int DEF_N_INT        = 2;
   localparam int DEF_CAR_FETCH    = 0;
   localparam int DEF_CAR_RST_VEC  = 4;
   localparam int DEF_INT_VEC_BASE = 8;
   localparam int DEF_INT_VEC_STEP = 2;

   // Next-CAR source select, listed in decreasing priority.
   typedef logic [2:0] nxt_sel_t;
   localparam nxt_sel_t SEL_HOLD = 3'd0;
   localparam nxt_sel_t SEL_BR   = 3'd1;
   localparam nxt_sel_t SEL_INT  = 3'd2;
   localparam nxt_sel_t SEL_NEW  = 3'd3;
   localparam nxt_sel_t SEL_CALL = 3'd4;
   localparam nxt_sel_t SEL_RET  = 3'd5;
   localparam nxt_sel_t SEL_INC  = 3'd6;

endpackage

// File: rtl/micro_sequencer_ustack.sv
// ---------------------------------------------------------------------------
// ustack_lifo
//   DEPTH x WIDTH micro-return stack.
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset (empties the stack)
//     push_i, din_i  push din_i; ignored when full (oldest entries kept)
//     pop_i          pop top; ignored when empty
//     flush_i        empty the stack; beats push/pop
//     top_o          current top entry (0 when empty)
//     full_o/empty_o occupancy flags
//     depth_o        number of occupied entries
// ---------------------------------------------------------------------------
module ustack_lifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 6,
   localparam int DW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] top_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [DW-1:0]    depth_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [DW-1:0]    depth_q;
   logic [DW-1:0]    depth_d;
   logic             wr_en;

   assign full_o  = (depth_q == DW'(DEPTH));
   assign empty_o = (depth_q == '0);
   assign depth_o = depth_q;
   assign wr_en   = push_i && !full_o && !flush_i;

   // Entries are only read while occupied, so the array needs no reset.
   assign top_o = empty_o ? '0 : mem_q[depth_q - DW'(1)];

   always_comb begin
      depth_d = depth_q;
      if (flush_i)                 depth_d = '0;
      else if (wr_en)              depth_d = depth_q + DW'(1);
      else if (pop_i && !empty_o)  depth_d = depth_q - DW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) depth_q <= '0;
      else        depth_q <= depth_d;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[depth_q] <= din_i;
   end

endmodule

// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer
//   Owns the control-address register (CAR) and selects the next
//   microinstruction address each cycle: stall, branch-to-fetch, interrupt
//   vector, decoder entry, micro-call, micro-return or sequential step.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset
//     stall       hold everything this cycle
//     if_req      fetch boundary; car_new valid, interrupts may be taken
//     br          end of uSeq with PC write; go to fetch, flush stack
//     call        push car+1, jump to call_tgt
//     ret         pop return address into car
//     int_req     level requests, bit 0 highest priority
//     car_new     decoder entry address
//     car         registered control address
//     int_ack     one-hot pulse for the vector taken
//     stk_depth   return-stack occupancy
//     stk_err     sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module micro_sequencer
   import micro_sequencer_pkg::*;
#(
   parameter  int CAR_BITS     = DEF_CAR_BITS,
   parameter  int STACK_DEPTH  = DEF_STACK_DEPTH,
   parameter  int N_INT        = DEF_N_INT,
   parameter  int CAR_FETCH    = DEF_CAR_FETCH,
   parameter  int CAR_RST_VEC  = DEF_CAR_RST_VEC,
   parameter  int INT_VEC_BASE = DEF_INT_VEC_BASE,
   parameter  int INT_VEC_STEP = DEF_INT_VEC_STEP,
   localparam int DW           = $clog2(STACK_DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                if_req,
   input  logic                br,
   input  logic                call,
   input  logic [CAR_BITS-1:0] call_tgt,
   input  logic                ret,
   input  logic [N_INT-1:0]    int_req,
   input  logic [CAR_BITS-1:0] car_new,
   output logic [CAR_BITS-1:0] car,
   output logic [N_INT-1:0]    int_ack,
   output logic [DW-1:0]       stk_depth,
   output logic                stk_err
);

   if (INT_VEC_BASE + (N_INT - 1) * INT_VEC_STEP >= (1 << CAR_BITS)) begin : g_vec_chk
      $error("micro_sequencer: highest interrupt vector does not fit CAR_BITS");
   end
   if (STACK_DEPTH < 1) begin : g_depth_chk
      $error("micro_sequencer: STACK_DEPTH must be at least 1");
   end

   logic [CAR_BITS-1:0] car_q, car_d, car_inc;
   logic [N_INT-1:0]    int_ack_q, int_ack_d;
   logic                stk_err_q, stk_err_d;

   logic                int_hit;
   logic [N_INT-1:0]    int_oh;
   logic [CAR_BITS-1:0] int_vec;
   nxt_sel_t            sel;

   logic                stk_push, stk_pop, stk_flush;
   logic                stk_full, stk_empty;
   logic [CAR_BITS-1:0] stk_top;

   assign car_inc = car_q + CAR_BITS'(1);

   // Lowest set request wins: scan from the top so the last hit overrides.
   always_comb begin
      int_hit = 1'b0;
      int_oh  = '0;
      int_vec = '0;
      for (int i = N_INT - 1; i >= 0; i--) begin
         if (int_req[i]) begin
            int_hit   = 1'b1;
            int_oh    = '0;
            int_oh[i] = 1'b1;
            int_vec   = CAR_BITS'(INT_VEC_BASE + i * INT_VEC_STEP);
         end
      end
   end

   always_comb begin
      if (stall)                  sel = SEL_HOLD;
      else if (br)                sel = SEL_BR;
      else if (if_req && int_hit) sel = SEL_INT;
      else if (if_req)            sel = SEL_NEW;
      else if (call)              sel = SEL_CALL;
      else if (ret)               sel = SEL_RET;
      else                        sel = SEL_INC;
   end

   always_comb begin
      car_d     = car_q;
      int_ack_d = '0;
      stk_err_d = stk_err_q;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_flush = 1'b0;
      case (sel)
         SEL_HOLD: ;
         SEL_BR: begin
            car_d     = CAR_BITS'(CAR_FETCH);
            stk_flush = 1'b1;
         end
         SEL_INT: begin
            car_d     = int_vec;
            int_ack_d = int_oh;
            stk_flush = 1'b1;
         end
         SEL_NEW: begin
            car_d     = car_new;
            stk_flush = 1'b1;
         end
         SEL_CALL: begin
            // A full stack drops the push but the jump still happens.
            car_d    = call_tgt;
            stk_push = 1'b1;
            if (stk_full) stk_err_d = 1'b1;
         end
         SEL_RET: begin
            // Underflow recovers by restarting at the fetch sequence.
            if (stk_empty) begin
               car_d     = CAR_BITS'(CAR_FETCH);
               stk_err_d = 1'b1;
            end else begin
               car_d   = stk_top;
               stk_pop = 1'b1;
            end
         end
         default: car_d = car_inc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         car_q     <= CAR_BITS'(CAR_RST_VEC);
         int_ack_q <= '0;
         stk_err_q <= 1'b0;
      end else begin
         car_q     <= car_d;
         int_ack_q <= int_ack_d;
         stk_err_q <= stk_err_d;
      end
   end

   ustack_lifo #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (CAR_BITS)
   ) u_stack (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (stk_push),
      .pop_i   (stk_pop),
      .flush_i (stk_flush),
      .din_i   (car_inc),
      .top_o   (stk_top),
      .full_o  (stk_full),
      .empty_o (stk_empty),
      .depth_o (stk_depth)
   );

   assign car     = car_q;
   assign int_ack = int_ack_q;
   assign stk_err = stk_err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_micro_sequencer
//   Drives two sequencers from one stimulus stream: the default build
//   (6-bit CAR, 4-deep stack, 2 interrupts) and a wide build (8-bit CAR,
//   8-deep stack, 4 interrupts). A behavioural model per build predicts
//   car/int_ack/stk_depth/stk_err every cycle; directed steps add literal
//   expectations for the documented scenarios.
// ---------------------------------------------------------------------------
module tb_micro_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, stall, br, if_req, call, ret;
   logic [7:0] call_tgt, car_new;
   logic [3:0] int_req;

   logic [5:0] car0;  logic [1:0] ack0;  logic [2:0] dep0;  logic err0;
   logic [7:0] car1;  logic [3:0] ack1;  logic [3:0] dep1;  logic err1;

   int n_chk  = 0;
   int n_fail = 0;

   micro_sequencer u0 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .if_req(if_req), .br(br),
      .call(call), .call_tgt(call_tgt[5:0]), .ret(ret), .int_req(int_req[1:0]),
      .car_new(car_new[5:0]), .car(car0), .int_ack(ack0), .stk_depth(dep0),
      .stk_err(err0)
   );

   micro_sequencer #(.CAR_BITS(8), .STACK_DEPTH(8), .N_INT(4)) u1 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .if_req(if_req), .br(br),
      .call(call), .call_tgt(call_tgt), .ret(ret), .int_req(int_req),
      .car_new(car_new), .car(car1), .int_ack(ack1), .stk_depth(dep1),
      .stk_err(err1)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int  mcar [2];
   int  mdep [2];
   int  merr [2];
   int  mack [2];
   int  mstk [2][8];
   bit  mvalid = 1'b0;

   task automatic model_step(input int i);
      int cbits, sd, ni, mask, req, k;
      cbits = (i == 0) ? 6 : 8;
      sd    = (i == 0) ? 4 : 8;
      ni    = (i == 0) ? 2 : 4;
      mask  = (1 << cbits) - 1;
      req   = int'(int_req) & ((1 << ni) - 1);
      if (!rst_n) begin
         mcar[i] = 4; mdep[i] = 0; merr[i] = 0; mack[i] = 0;
         return;
      end
      mack[i] = 0;
      if (stall) return;
      if (br) begin
         mcar[i] = 0; mdep[i] = 0;
      end else if (if_req && req != 0) begin
         k = 0;
         while (((req >> k) & 1) == 0) k++;
         mcar[i] = (8 + 2 * k) & mask;
         mack[i] = 1 << k;
         mdep[i] = 0;
      end else if (if_req) begin
         mcar[i] = int'(car_new) & mask;
         mdep[i] = 0;
      end else if (call) begin
         if (mdep[i] < sd) begin
            mstk[i][mdep[i]] = (mcar[i] + 1) & mask;
            mdep[i]++;
         end else merr[i] = 1;
         mcar[i] = int'(call_tgt) & mask;
      end else if (ret) begin
         if (mdep[i] > 0) begin
            mdep[i]--;
            mcar[i] = mstk[i][mdep[i]];
         end else begin
            mcar[i] = 0;
            merr[i] = 1;
         end
      end else mcar[i] = (mcar[i] + 1) & mask;
   endtask

   // Inputs change just after posedge; at negedge they are the ones the
   // next posedge will consume, so compare first and then advance the model.
   always @(negedge clk) begin
      if (mvalid) begin
         chk("m_car0", int'(car0), mcar[0]);
         chk("m_ack0", int'(ack0), mack[0]);
         chk("m_dep0", int'(dep0), mdep[0]);
         chk("m_err0", int'(err0), merr[0]);
         chk("m_car1", int'(car1), mcar[1]);
         chk("m_ack1", int'(ack1), mack[1]);
         chk("m_dep1", int'(dep1), mdep[1]);
         chk("m_err1", int'(err1), merr[1]);
      end
      model_step(0);
      model_step(1);
      if (!rst_n) mvalid = 1'b1;
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      rst_n = 1'b1; stall = 1'b0; br = 1'b0; if_req = 1'b0; call = 1'b0;
      ret = 1'b0; call_tgt = '0; car_new = '0; int_req = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst_n = 1'b0; br = 1'b1; int_req = 4'd3;
      tick(); tick();
      chk("rst_car0", int'(car0), 4);
      chk("rst_ack0", int'(ack0), 0);
      chk("rst_dep0", int'(dep0), 0);
      chk("rst_err0", int'(err0), 0);
      chk("rst_car1", int'(car1), 4);

      idle(); tick();
      chk("inc_car0", int'(car0), 5);
      idle(); if_req = 1'b1; int_req = 4'b0011; tick();
      chk("int0_car0", int'(car0), 8);
      chk("int0_ack0", int'(ack0), 1);
      chk("int0_ack1", int'(ack1), 1);
      idle(); if_req = 1'b1; int_req = 4'b0010; tick();
      chk("int1_car0", int'(car0), 10);
      chk("int1_ack0", int'(ack0), 2);
      idle(); tick();
      chk("ack_pulse0", int'(ack0), 0);

      idle(); if_req = 1'b1; car_new = 8'd6; tick();
      chk("new_car0", int'(car0), 6);
      idle(); call = 1'b1; call_tgt = 8'd20; tick();
      chk("call1_car0", int'(car0), 20);
      idle(); call = 1'b1; call_tgt = 8'd30; tick();
      chk("call2_car0", int'(car0), 30);
      chk("call2_dep0", int'(dep0), 2);
      idle(); ret = 1'b1; tick();
      chk("ret1_car0", int'(car0), 21);
      idle(); ret = 1'b1; tick();
      chk("ret2_car0", int'(car0), 7);
      chk("ret2_dep0", int'(dep0), 0);

      for (int n = 0; n < 5; n++) begin
         idle(); call = 1'b1; call_tgt = 8'(40 + n); tick();
         if (n == 3) begin
            chk("ovf4_dep0", int'(dep0), 4);
            chk("ovf4_err0", int'(err0), 0);
         end
      end
      chk("ovf_car0", int'(car0), 44);
      chk("ovf_err0", int'(err0), 1);
      chk("ovf_dep0", int'(dep0), 4);
      chk("ovf_dep1", int'(dep1), 5);
      chk("ovf_err1", int'(err1), 0);

      idle(); rst_n = 1'b0; tick();
      chk("rst2_err0", int'(err0), 0);
      idle(); ret = 1'b1; tick();
      chk("unf_car0", int'(car0), 0);
      chk("unf_err0", int'(err0), 1);

      idle(); tick();
      chk("pre_stall_car0", int'(car0), 1);
      idle(); stall = 1'b1; br = 1'b1; if_req = 1'b1; int_req = 4'b0011; tick();
      chk("stall_car0", int'(car0), 1);
      chk("stall_ack0", int'(ack0), 0);
      chk("stall_err0", int'(err0), 1);
      stall = 1'b0; tick();
      chk("br_car0", int'(car0), 0);
      chk("br_ack0", int'(ack0), 0);

      idle(); if_req = 1'b1; car_new = 8'd63; tick();
      chk("c63_car0", int'(car0), 63);
      idle(); tick();
      chk("wrap_car0", int'(car0), 0);
      chk("nowrap_car1", int'(car1), 64);

      idle(); if_req = 1'b1; car_new = 8'd255; tick();
      idle(); tick();
      chk("wrap_car1", int'(car1), 0);

      for (int n = 0; n < 3000; n++) begin
         idle();
         rst_n    = ($urandom_range(199) != 0);
         stall    = ($urandom_range(9) == 0);
         br       = ($urandom_range(19) == 0);
         if_req   = ($urandom_range(6) == 0);
         call     = ($urandom_range(3) == 0);
         ret      = ($urandom_range(2) == 0);
         call_tgt = 8'($urandom);
         car_new  = 8'($urandom);
         int_req  = ($urandom_range(1) == 0) ? 4'($urandom) : 4'd0;
         tick();
      end

      idle(); tick(); tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
